mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, 64, data width in bits; legal values 32 and 64.
REQ-002 Parameter AW, 27, byte-address width.
REQ-003 Clocking SHALL be one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 i_req_valid/i_req_ready  in/out  1/1  instruction-fetch request handshake.
REQ-007 i_req_addr  in  AW  fetch byte address.
REQ-008 i_rsp_valid/i_rsp_ready  out/in  1/1  fetch response handshake.
REQ-009 i_rsp_instr/i_rsp_err  out/out  32/1  fetched instruction and misalignment error.
REQ-010 d_req_valid/d_req_ready  in/out  1/1  data request handshake.
REQ-011 d_req_wr, d_req_strb, d_req_addr, d_req_wdata  in  1, XLEN/8, AW, XLEN  write flag, byte strobes, byte address, write data.
REQ-012 d_rsp_valid/d_rsp_ready  out/in  1/1  data response handshake, returned for reads and writes.
REQ-013 d_rsp_rdata/d_rsp_err  out/out  XLEN/1  strobe-masked read data and error.
REQ-014 mem_cen, mem_wr, mem_strb, mem_addr, mem_wdata  out  1, 1, XLEN/8, AW, XLEN  single shared memory port.
REQ-015 mem_rdata/mem_error  in/in  XLEN/1  combinational same-cycle memory read data and error.

Function
REQ-016 A request SHALL be accepted in the cycle where valid and ready are both high.
REQ-017 x_req_ready SHALL be high only when the FSM is in IDLE, the port's response register is empty, and the port wins arbitration.
REQ-018 FSM states SHALL be IDLE, ACC_I and ACC_D; acceptance moves IDLE to ACC_x; ACC_x SHALL always return to IDLE after exactly one cycle.
REQ-019 In ACC_x, the memory port SHALL be driven from the captured request, mem_cen SHALL be 1, and the response SHALL be registered at the end of that cycle.
REQ-020 x_rsp_valid SHALL rise on the cycle after ACC_x; acceptance-to-response latency SHALL be 2 cycles; peak throughput SHALL be one access per 2 cycles.
REQ-021 Arbitration SHALL be round-robin, using a last-grant bit, on simultaneous eligible requests.
REQ-022 The last-grant bit SHALL reset to D, so I wins the first tie.
REQ-023 A lone eligible requester SHALL win regardless of the last-grant bit.
REQ-024 The last-grant bit SHALL update only on acceptance.
REQ-025 Fetch access SHALL drive mem_wr=0, mem_strb with the low 4 bits set and the rest cleared, mem_wdata=0, and i_rsp_instr=mem_rdata[31:0].
REQ-026 A fetch with i_req_addr[1:0]!=0 SHALL still consume ACC_I, but mem_cen SHALL be 0, and the response SHALL be i_rsp_err=1, i_rsp_instr=0.
REQ-027 Data access SHALL pass d_req_wr, d_req_strb, d_req_addr and d_req_wdata through to the memory port.
REQ-028 Data read response SHALL be d_rsp_rdata = mem_rdata with bytes whose strobe is 0 zeroed.
REQ-029 Data write response SHALL be d_rsp_rdata=0.
REQ-030 Data response error SHALL be d_rsp_err=mem_error.
REQ-031 A data request with d_req_strb=0 SHALL complete with mem_cen=0 and d_rsp_err=0.
REQ-032 A response register SHALL hold its values stable while valid is high and ready is low.
REQ-033 A response register SHALL clear when valid and ready are both high.
REQ-034 A port with a pending response SHALL NOT be granted, and the other port SHALL remain eligible.
REQ-035 In IDLE, mem_cen and mem_wr SHALL be 0, and mem_addr, mem_strb and mem_wdata SHALL be 0.

Reset
REQ-036 While rst=1, the FSM SHALL be IDLE, last-grant SHALL be D, all *_rsp_valid, *_req_ready, mem_cen and mem_wr SHALL be 0, and all data outputs SHALL be 0.
REQ-037 Reset asserted during ACC_x SHALL abort the access, with no response produced; a write SHALL have been issued only in cycles completed before reset.
REQ-038 The first grant SHALL be possible in the first clock edge after rst deasserts.

Verification
REQ-039 Single fetch: after reset, memory word at 0x100 = 0x00000013; i_req at 0x100 -> accepted cycle 0, mem_cen=1 and mem_addr=0x100 in cycle 1, i_rsp_valid=1 with i_rsp_instr=0x00000013 in cycle 2, i_rsp_err=0.
REQ-040 Tie and round-robin: I and D both requesting continuously, rsp_ready=1 -> grant order I, D, I, D; each grant 2 cycles apart.
REQ-041 Back-pressure: d_rsp_ready=0 after a D read of 0x1122334455667788 with strb=0x0F -> d_rsp_rdata=0x0000000055667788, held stable; further D requests not granted; I requests granted; release ready -> next D accepted.
REQ-042 Write then read: D write addr 0x200, wdata 0xAABBCCDDEEFF0011, strb 0xF0 -> d_rsp_rdata=0; then D read at 0x200 with strb 0xFF -> upper 4 bytes 0xAABBCCDD, lower 4 bytes unchanged.
REQ-043 Misaligned fetch: i_req_addr=0x102 -> mem_cen stays 0, i_rsp_err=1, i_rsp_instr=0, latency 2.
REQ-044 Reset mid-access: assert rst during ACC_D of a write -> no d_rsp_valid; all outputs are 0 the same cycle; normal grant resumes after deassert.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle memory port between an instruction
// fetch port (I) and a data port (D).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   i_req_*           fetch request  (valid/ready, byte address)
//   i_rsp_*           fetch response (valid/ready, 32-bit instruction, misalign error)
//   d_req_*           data request   (valid/ready, wr, byte strobes, address, wdata)
//   d_rsp_*           data response  (valid/ready, strobe-masked rdata, error)
//   mem_*             shared memory port; mem_rdata/mem_error are same-cycle
//   dbg_state         current FSM state (IDLE=0, ACC_I=1, ACC_D=2)
//
// Handshake rule (all four channels): a transfer happens on the rising edge
// where valid and ready are both high. A response register holds its contents
// while valid=1 and ready=0, and clears on the transfer.
//
// Each accepted request spends one cycle in ACC_x driving the memory port.
// Its response is registered at the end of that cycle, so the response is
// visible two cycles after acceptance.
module mem_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [AW-1:0]     i_req_addr,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_instr,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_wr,
  input  logic [XLEN/8-1:0] d_req_strb,
  input  logic [AW-1:0]     d_req_addr,
  input  logic [XLEN-1:0]   d_req_wdata,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [XLEN-1:0]   d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              mem_cen,
  output logic              mem_wr,
  output logic [XLEN/8-1:0] mem_strb,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_error,
  output logic [1:0]        dbg_state
);

  localparam int SW = XLEN / 8;
  localparam logic [SW-1:0] FETCH_STRB = SW'(4'hF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  // 1: last accepted request was D, so I wins the next tie.
  logic last_d_q;

  // Request captured at acceptance and replayed onto the memory port in ACC_x.
  logic              cap_wr_q;
  logic [SW-1:0]     cap_strb_q;
  logic [AW-1:0]     cap_addr_q;
  logic [XLEN-1:0]   cap_wdata_q;
  // Access completes without touching memory (misaligned fetch or empty strobe).
  logic              cap_nop_q;

  logic i_elig, d_elig, grant_i, grant_d, i_acc, d_acc;
  logic [XLEN-1:0] strb_mask;

  assign dbg_state = state_q;

  // A port with an unconsumed response is not eligible; round-robin only
  // matters when both ports are eligible.
  always_comb begin
    i_elig  = i_req_valid && !i_rsp_valid;
    d_elig  = d_req_valid && !d_rsp_valid;
    grant_i = i_elig && (!d_elig || last_d_q);
    grant_d = d_elig && (!i_elig || !last_d_q);
  end

  assign i_req_ready = !rst && (state_q == IDLE) && grant_i;
  assign d_req_ready = !rst && (state_q == IDLE) && grant_d;
  assign i_acc       = i_req_valid && i_req_ready;
  assign d_acc       = d_req_valid && d_req_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_acc)      state_d = ACC_I;
        else if (d_acc) state_d = ACC_D;
      end
      ACC_I:   state_d = IDLE;
      ACC_D:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port is all-zero outside ACC_x; the fetch capture already holds
  // wr=0, the fixed low-word strobe and zero write data.
  always_comb begin
    mem_cen   = 1'b0;
    mem_wr    = 1'b0;
    mem_strb  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ACC_I || state_q == ACC_D) begin
      mem_cen   = !cap_nop_q;
      mem_wr    = cap_wr_q;
      mem_strb  = cap_strb_q;
      mem_addr  = cap_addr_q;
      mem_wdata = cap_wdata_q;
    end
  end

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < SW; b++) begin
      strb_mask[b*8 +: 8] = {8{cap_strb_q[b]}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cap_wr_q    <= 1'b0;
      cap_strb_q  <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_nop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (i_acc) begin
        last_d_q    <= 1'b0;
        cap_wr_q    <= 1'b0;
        cap_strb_q  <= FETCH_STRB;
        cap_addr_q  <= i_req_addr;
        cap_wdata_q <= '0;
        cap_nop_q   <= (i_req_addr[1:0] != 2'b00);
      end else if (d_acc) begin
        last_d_q    <= 1'b1;
        cap_wr_q    <= d_req_wr;
        cap_strb_q  <= d_req_strb;
        cap_addr_q  <= d_req_addr;
        cap_wdata_q <= d_req_wdata;
        cap_nop_q   <= (d_req_strb == '0);
      end
    end
  end

  // Response registers. They are always empty during ACC_x of their own port
  // (eligibility required it), so load and clear never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rsp_valid <= 1'b0;
      i_rsp_instr <= '0;
      i_rsp_err   <= 1'b0;
    end else if (state_q == ACC_I) begin
      i_rsp_valid <= 1'b1;
      i_rsp_instr <= cap_nop_q ? 32'h0 : mem_rdata[31:0];
      i_rsp_err   <= cap_nop_q;
    end else if (i_rsp_valid && i_rsp_ready) begin
      i_rsp_valid <= 1'b0;
      i_rsp_instr <= '0;
      i_rsp_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= '0;
      d_rsp_err   <= 1'b0;
    end else if (state_q == ACC_D) begin
      d_rsp_valid <= 1'b1;
      d_rsp_rdata <= cap_wr_q ? '0 : (mem_rdata & strb_mask);
      d_rsp_err   <= cap_nop_q ? 1'b0 : mem_error;
    end else if (d_rsp_valid && d_rsp_ready) begin
      d_rsp_valid <= 1'b0;
      d_rsp_rdata <= '0;
      d_rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (XLEN=64, AW=27) with a behavioural
// single-cycle memory. Inputs change and outputs are sampled 1 ns after the
// falling edge.
module tb_mem_arbiter;

  localparam int XLEN = 64;
  localparam int AW   = 27;
  localparam int SW   = XLEN / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            i_req_valid, i_req_ready;
  logic [AW-1:0]   i_req_addr;
  logic            i_rsp_valid, i_rsp_ready;
  logic [31:0]     i_rsp_instr;
  logic            i_rsp_err;
  logic            d_req_valid, d_req_ready, d_req_wr;
  logic [SW-1:0]   d_req_strb;
  logic [AW-1:0]   d_req_addr;
  logic [XLEN-1:0] d_req_wdata;
  logic            d_rsp_valid, d_rsp_ready;
  logic [XLEN-1:0] d_rsp_rdata;
  logic            d_rsp_err;
  logic            mem_cen, mem_wr;
  logic [SW-1:0]   mem_strb;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata, mem_rdata;
  logic            mem_error;
  logic [1:0]      dbg_state;

  mem_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .i_rsp_instr(i_rsp_instr), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_wr(d_req_wr),
    .d_req_strb(d_req_strb), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
    .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_cen(mem_cen), .mem_wr(mem_wr), .mem_strb(mem_strb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  // Word index = addr[10:3]: 0x100->32, 0x200->64, 0x300->96, 0x400->128, 0x500->160.
  logic [63:0] mem [0:255];
  logic        mem_err_force;
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [63:0] pre_val;

  always_comb begin
    mem_rdata = mem[mem_addr[10:3]];
    mem_error = mem_err_force;
  end

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (mem_cen && mem_wr) begin
      for (int b = 0; b < SW; b++) begin
        if (mem_strb[b]) mem[mem_addr[10:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preset(input logic [7:0] idx, input logic [63:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic set_d(input logic wr, input logic [AW-1:0] addr,
                       input logic [SW-1:0] strb, input logic [XLEN-1:0] wdata);
    d_req_valid = 1'b1;
    d_req_wr    = wr;
    d_req_addr  = addr;
    d_req_strb  = strb;
    d_req_wdata = wdata;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    i_req_valid = 0; i_req_addr = '0; i_rsp_ready = 1'b1;
    d_req_valid = 0; d_req_wr = 0; d_req_strb = '0; d_req_addr = '0; d_req_wdata = '0;
    d_rsp_ready = 1'b1;
    mem_err_force = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;

    preset(8'd32,  64'h0000_0000_0000_0013);
    preset(8'd64,  64'h0102_0304_0506_0708);
    preset(8'd96,  64'hDEAD_BEEF_CAFE_F00D);
    preset(8'd128, 64'h1122_3344_5566_7788);
    preset(8'd160, 64'h0);

    // Reset state, with requests pending
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 27'h100;
    set_d(1'b0, 27'h300, 8'hFF, '0);
    #1;
    check("rst_i_ready", i_req_ready, 0);
    check("rst_d_ready", d_req_ready, 0);
    check("rst_state",   dbg_state, 0);
    check("rst_outs",    {i_rsp_valid, d_rsp_valid, mem_cen, mem_wr}, 0);
    check("rst_data",    mem_addr | mem_strb | mem_wdata | d_rsp_rdata | i_rsp_instr, 0);
    i_req_valid = 0; d_req_valid = 0;

    // Single fetch, first grant right after reset
    @(negedge clk);
    rst = 0; i_req_valid = 1; i_req_addr = 27'h100;
    #1 check("f1_ready_c0", i_req_ready, 1);
    @(negedge clk); i_req_valid = 0;
    #1;
    check("f1_state_c1", dbg_state, 1);
    check("f1_cen_c1",   mem_cen, 1);
    check("f1_addr_c1",  mem_addr, 27'h100);
    check("f1_strb_c1",  mem_strb, 8'h0F);
    check("f1_wr_c1",    {mem_wr, mem_wdata}, 0);
    check("f1_novalid_c1", i_rsp_valid, 0);
    @(negedge clk); #1;
    check("f1_valid_c2", i_rsp_valid, 1);
    check("f1_instr_c2", i_rsp_instr, 32'h13);
    check("f1_err_c2",   i_rsp_err, 0);
    check("f1_idle_mem", {mem_cen, mem_addr}, 0);
    @(negedge clk); #1;
    check("f1_consumed", i_rsp_valid, 0);

    // Tie after an I grant and drained responses: D must win
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 27'h100;
    set_d(1'b0, 27'h300, 8'hFF, '0);
    #1 check("rr_tie_after_i", {i_req_ready, d_req_ready}, 2'b01);
    @(negedge clk);
    i_req_valid = 0; d_req_valid = 0;
    repeat (2) @(negedge clk);

    // Tie right after reset: I, D, I, D, two cycles apart
    rst = 1;
    @(negedge clk);
    rst = 0;
    i_req_valid = 1; i_req_addr = 27'h100;
    set_d(1'b0, 27'h300, 8'hFF, '0);
    exp_q = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    for (int c = 0; c < 8; c++) begin
      #1 check($sformatf("tie_grant_c%0d", c), {i_req_ready, d_req_ready}, exp_q.pop_front());
      @(negedge clk);
    end
    i_req_valid = 0; d_req_valid = 0;
    repeat (2) @(negedge clk);

    // Back-pressure on the data response
    d_rsp_ready = 0;
    set_d(1'b0, 27'h400, 8'h0F, '0);
    #1 check("bp_d_ready_c0", d_req_ready, 1);
    @(negedge clk);
    d_req_strb = 8'hFF;
    i_req_valid = 1; i_req_addr = 27'h100;
    @(negedge clk); #1;
    check("bp_rsp_valid_c2", d_rsp_valid, 1);
    check("bp_rdata_c2",     d_rsp_rdata, 64'h0000_0000_5566_7788);
    check("bp_d_blocked_c2", d_req_ready, 0);
    check("bp_i_granted_c2", i_req_ready, 1);
    @(negedge clk); i_req_valid = 0;
    #1;
    check("bp_acc_i_c3", {dbg_state, mem_cen}, {2'd1, 1'b1});
    check("bp_hold_c3",  d_rsp_rdata, 64'h0000_0000_5566_7788);
    @(negedge clk); #1;
    check("bp_i_rsp_c4",  {i_rsp_valid, i_rsp_instr}, {1'b1, 32'h13});
    check("bp_hold_c4",   {d_rsp_valid, d_rsp_rdata}, {1'b1, 64'h0000_0000_5566_7788});
    check("bp_d_blocked_c4", d_req_ready, 0);
    d_rsp_ready = 1;
    @(negedge clk); #1;
    check("bp_released_c5", {d_rsp_valid, d_req_ready}, 2'b01);
    @(negedge clk); d_req_valid = 0;
    @(negedge clk); #1;
    check("bp_second_rd", {d_rsp_valid, d_rsp_rdata}, {1'b1, 64'h1122_3344_5566_7788});
    @(negedge clk);

    // Write then read back
    set_d(1'b1, 27'h200, 8'hF0, 64'hAABB_CCDD_EEFF_0011);
    #1 check("wr_ready", d_req_ready, 1);
    @(negedge clk); d_req_valid = 0;
    #1;
    check("wr_port_ctl", {mem_cen, mem_wr, mem_strb}, {1'b1, 1'b1, 8'hF0});
    check("wr_port_addr", mem_addr, 27'h200);
    check("wr_port_data", mem_wdata, 64'hAABB_CCDD_EEFF_0011);
    @(negedge clk); #1;
    check("wr_rsp", {d_rsp_valid, d_rsp_err, d_rsp_rdata}, {1'b1, 1'b0, 64'h0});
    @(negedge clk);
    set_d(1'b0, 27'h200, 8'hFF, '0);
    mem_err_force = 1;
    #1 check("rd_ready", d_req_ready, 1);
    @(negedge clk); d_req_valid = 0;
    @(negedge clk); #1;
    check("rd_data", d_rsp_rdata, 64'hAABB_CCDD_0506_0708);
    check("rd_err",  {d_rsp_valid, d_rsp_err}, 2'b11);
    mem_err_force = 0;

    // Misaligned fetch
    @(negedge clk);
    i_req_valid = 1; i_req_addr = 27'h102;
    #1 check("mis_ready", i_req_ready, 1);
    @(negedge clk); i_req_valid = 0;
    #1 check("mis_acc_nocen", {dbg_state, mem_cen}, {2'd1, 1'b0});
    @(negedge clk); #1;
    check("mis_rsp", {i_rsp_valid, i_rsp_err, i_rsp_instr}, {1'b1, 1'b1, 32'h0});

    // Empty strobe on data port
    @(negedge clk);
    set_d(1'b0, 27'h400, 8'h00, '0);
    mem_err_force = 1;
    @(negedge clk); d_req_valid = 0;
    #1 check("nostrb_acc", {dbg_state, mem_cen}, {2'd2, 1'b0});
    @(negedge clk); #1;
    check("nostrb_rsp", {d_rsp_valid, d_rsp_err, d_rsp_rdata}, {1'b1, 1'b0, 64'h0});
    mem_err_force = 0;

    // Reset during ACC_D of a write
    @(negedge clk);
    set_d(1'b1, 27'h500, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    #1 check("rm_ready", d_req_ready, 1);
    @(negedge clk); d_req_valid = 0;
    #1 check("rm_acc", {dbg_state, mem_cen, mem_wr}, {2'd2, 1'b1, 1'b1});
    rst = 1;
    #1;
    check("rm_abort_ctl", {dbg_state, mem_cen, mem_wr, d_rsp_valid, i_rsp_valid}, 0);
    check("rm_abort_data", mem_addr | mem_strb | mem_wdata | d_rsp_rdata, 0);
    @(negedge clk); #1;
    check("rm_no_rsp_rst", d_rsp_valid, 0);
    rst = 0;
    @(negedge clk); #1;
    check("rm_no_rsp_after", d_rsp_valid, 0);
    check("rm_no_write", mem[160], 64'h0);
    i_req_valid = 1; i_req_addr = 27'h100;
    #1 check("rm_resume_ready", i_req_ready, 1);
    @(negedge clk); i_req_valid = 0;
    @(negedge clk); #1;
    check("rm_resume_rsp", {i_rsp_valid, i_rsp_instr}, {1'b1, 32'h13});

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
